// File: rtl/mux_key.sv
`default_nettype none
// ============================================================================
// Module   : mux_key
// Purpose  : Keyed multiplexer. Looks up `key` in a packed table of
//            key/value pairs and returns the data of the first matching
//            pair, together with a match flag and a duplicate-key flag.
//            A registered copy of all three results is also provided.
//
// Parameters
//   NR_KEY    number of key/value pairs (>= 1)
//   KEY_LEN   key width in bits (>= 1)
//   DATA_LEN  data width in bits (>= 1)
//
// Ports
//   clk    in   1                  clock, rising edge
//   rst_n  in   1                  asynchronous active-low reset (registers only)
//   key    in   KEY_LEN            lookup key
//   lut    in   NR_KEY*PAIR_LEN    packed table {key_0,data_0,key_1,data_1,...}
//   out    out  DATA_LEN           selected data (combinational)
//   hit    out  1                  at least one pair matched (combinational)
//   dup    out  1                  two or more pairs matched (combinational)
//   out_q  out  DATA_LEN           out, registered
//   hit_q  out  1                  hit, registered
//   dup_q  out  1                  dup, registered
//
// Revision : 1.0  initial release
// ============================================================================
module mux_key #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [KEY_LEN-1:0]                 key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                out,
  output logic                               hit,
  output logic                               dup,
  output logic [DATA_LEN-1:0]                out_q,
  output logic                               hit_q,
  output logic                               dup_q
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;
  localparam int LUT_LEN  = NR_KEY * PAIR_LEN;

  // --------------------------------------------------------------------------
  // Table unpacking and per-pair key compare.
  // Pair 0 is the first pair in the concatenation, so it lives in the MSBs.
  // --------------------------------------------------------------------------
  logic [KEY_LEN-1:0]  pair_key  [NR_KEY];
  logic [DATA_LEN-1:0] pair_data [NR_KEY];
  logic [NR_KEY-1:0]   match;

  genvar gi;
  generate
    for (gi = 0; gi < NR_KEY; gi++) begin : g_pair
      localparam int PAIR_MSB = LUT_LEN - 1 - gi * PAIR_LEN;
      assign pair_key[gi]  = lut[PAIR_MSB -: KEY_LEN];
      assign pair_data[gi] = lut[PAIR_MSB - KEY_LEN -: DATA_LEN];
      assign match[gi]     = (pair_key[gi] == key);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Priority select. Walking upward from pair 0, the first match claims the
  // output; any later match only marks the key as duplicated. This gives
  // lowest-index-wins selection and a popcount>=2 flag in one pass.
  // --------------------------------------------------------------------------
  logic [DATA_LEN-1:0] sel_data;
  logic                sel_hit;
  logic                sel_dup;

  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    sel_dup  = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i]) begin
        if (sel_hit) begin
          sel_dup = 1'b1;
        end else begin
          sel_data = pair_data[i];
        end
        sel_hit = 1'b1;
      end
    end
  end

  assign out = sel_data;
  assign hit = sel_hit;
  assign dup = sel_dup;

  // --------------------------------------------------------------------------
  // Registered copies: one cycle of latency, no enable.
  // --------------------------------------------------------------------------
  logic [DATA_LEN-1:0] out_d;
  logic                hit_d;
  logic                dup_d;

  always_comb begin
    out_d = sel_data;
    hit_d = sel_hit;
    dup_d = sel_dup;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      hit_q <= 1'b0;
      dup_q <= 1'b0;
    end else begin
      out_q <= out_d;
      hit_q <= hit_d;
      dup_q <= dup_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_key.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_key
// Purpose  : Self-checking bench for mux_key. Three instances cover the
//            write-mask / duplicate-key tables (4x3x8), the byte-lane mux
//            (8x3x64) and the degenerate single-pair case (1x1x1).
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_key;

  localparam logic [43:0] WM_LUT  = {3'd0, 8'h01, 3'd1, 8'h03, 3'd2, 8'h0f, 3'd3, 8'hff};
  localparam logic [43:0] DUP_LUT = {3'd1, 8'hAA, 3'd1, 8'h55, 3'd0, 8'h11, 3'd2, 8'h22};
  localparam logic [43:0] TRI_LUT = {3'd4, 8'h10, 3'd4, 8'h20, 3'd4, 8'h30, 3'd4, 8'h40};
  localparam logic [43:0] TAIL_LUT = {3'd0, 8'h01, 3'd6, 8'h02, 3'd7, 8'h5a, 3'd7, 8'ha5};

  logic clk;
  logic rst_n;

  // instance A: 4 pairs, 3-bit key, 8-bit data
  logic [2:0]  key_a;
  logic [43:0] lut_a;
  logic [7:0]  out_a, out_q_a;
  logic        hit_a, dup_a, hit_q_a, dup_q_a;

  // instance B: byte-lane mux
  logic [2:0]   key_b;
  logic [535:0] lut_b;
  logic [63:0]  out_b, out_q_b;
  logic         hit_b, dup_b, hit_q_b, dup_q_b;

  // instance C: degenerate
  logic       key_c;
  logic [1:0] lut_c;
  logic       out_c, out_q_c;
  logic       hit_c, dup_c, hit_q_c, dup_q_c;

  mux_key #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(8)) u_a (
    .clk(clk), .rst_n(rst_n), .key(key_a), .lut(lut_a),
    .out(out_a), .hit(hit_a), .dup(dup_a),
    .out_q(out_q_a), .hit_q(hit_q_a), .dup_q(dup_q_a)
  );

  mux_key #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(64)) u_b (
    .clk(clk), .rst_n(rst_n), .key(key_b), .lut(lut_b),
    .out(out_b), .hit(hit_b), .dup(dup_b),
    .out_q(out_q_b), .hit_q(hit_q_b), .dup_q(dup_q_b)
  );

  mux_key #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .key(key_c), .lut(lut_c),
    .out(out_c), .hit(hit_c), .dup(dup_c),
    .out_q(out_q_c), .hit_q(hit_q_c), .dup_q(dup_q_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [43:0] lut;
    logic [2:0]  key;
    logic [7:0]  exp_out;
    logic        exp_hit;
    logic        exp_dup;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [43:0] l, input logic [2:0] k,
                         input logic [7:0] o, input logic h, input logic d);
    vec_t v;
    v.lut = l; v.key = k; v.exp_out = o; v.exp_hit = h; v.exp_dup = d;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] src;
    logic [63:0] exp_b [8];
    src = 64'h8877665544332211;
    exp_b[0] = 64'h11; exp_b[1] = 64'h22; exp_b[2] = 64'h33; exp_b[3] = 64'h44;
    exp_b[4] = 64'h55; exp_b[5] = 64'h66; exp_b[6] = 64'h77; exp_b[7] = 64'h88;

    // vector table for instance A
    add_vec(WM_LUT,   3'd0, 8'h01, 1'b1, 1'b0);
    add_vec(WM_LUT,   3'd1, 8'h03, 1'b1, 1'b0);
    add_vec(WM_LUT,   3'd2, 8'h0f, 1'b1, 1'b0);
    add_vec(WM_LUT,   3'd3, 8'hff, 1'b1, 1'b0);
    add_vec(WM_LUT,   3'd5, 8'h00, 1'b0, 1'b0);
    add_vec(WM_LUT,   3'd7, 8'h00, 1'b0, 1'b0);
    add_vec(DUP_LUT,  3'd1, 8'hAA, 1'b1, 1'b1);
    add_vec(DUP_LUT,  3'd0, 8'h11, 1'b1, 1'b0);
    add_vec(DUP_LUT,  3'd2, 8'h22, 1'b1, 1'b0);
    add_vec(DUP_LUT,  3'd3, 8'h00, 1'b0, 1'b0);
    add_vec(TRI_LUT,  3'd4, 8'h10, 1'b1, 1'b1);
    add_vec(TRI_LUT,  3'd5, 8'h00, 1'b0, 1'b0);
    add_vec(TAIL_LUT, 3'd7, 8'h5a, 1'b1, 1'b1);
    add_vec(TAIL_LUT, 3'd6, 8'h02, 1'b1, 1'b0);
    add_vec(WM_LUT,   3'd2, 8'h0f, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      lut_b[535 - i*67 -: 67] = {3'(i), 56'h0, src[i*8 +: 8]};
    end

    rst_n = 1'b0;
    key_a = 3'd0;
    lut_a = WM_LUT;
    key_b = 3'd0;
    key_c = 1'b0;
    lut_c = 2'b11;

    // reset state, before and across a clock edge
    #2;
    check("reset out_q", 64'(out_q_a), 64'h0);
    check("reset hit_q", 64'(hit_q_a), 64'h0);
    check("reset dup_q", 64'(dup_q_a), 64'h0);
    @(posedge clk); #1;
    check("reset held out_q", 64'(out_q_a), 64'h0);
    check("reset held hit_q", 64'(hit_q_a), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors: combinational then registered one edge later
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      lut_a = vecs[i].lut;
      key_a = vecs[i].key;
      #1;
      check($sformatf("vec%0d out", i), 64'(out_a), 64'(vecs[i].exp_out));
      check($sformatf("vec%0d hit", i), 64'(hit_a), 64'(vecs[i].exp_hit));
      check($sformatf("vec%0d dup", i), 64'(dup_a), 64'(vecs[i].exp_dup));
      @(posedge clk); #1;
      check($sformatf("vec%0d out_q", i), 64'(out_q_a), 64'(vecs[i].exp_out));
      check($sformatf("vec%0d hit_q", i), 64'(hit_q_a), 64'(vecs[i].exp_hit));
      check($sformatf("vec%0d dup_q", i), 64'(dup_q_a), 64'(vecs[i].exp_dup));
    end

    // reset asserted mid-cycle
    @(negedge clk);
    lut_a = WM_LUT;
    key_a = 3'd3;
    @(posedge clk); #1;
    check("pre-reset out_q", 64'(out_q_a), 64'hff);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_q", 64'(out_q_a), 64'h0);
    check("async reset hit_q", 64'(hit_q_a), 64'h0);
    check("async reset dup_q", 64'(dup_q_a), 64'h0);
    lut_a = DUP_LUT;
    key_a = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    check("in reset out_q", 64'(out_q_a), 64'h0);
    check("in reset hit_q", 64'(hit_q_a), 64'h0);
    check("in reset dup_q", 64'(dup_q_a), 64'h0);
    check("in reset comb out", 64'(out_a), 64'hAA);
    check("in reset comb dup", 64'(dup_a), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release no edge out_q", 64'(out_q_a), 64'h0);
    @(posedge clk); #1;
    check("release out_q", 64'(out_q_a), 64'hAA);
    check("release hit_q", 64'(hit_q_a), 64'h1);
    check("release dup_q", 64'(dup_q_a), 64'h1);

    // byte-lane sweep
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      key_b = 3'(k);
      #1;
      check($sformatf("lane%0d out", k), out_b, exp_b[k]);
      check($sformatf("lane%0d hit", k), 64'(hit_b), 64'h1);
      check($sformatf("lane%0d dup", k), 64'(dup_b), 64'h0);
    end
    @(posedge clk); #1;
    check("lane7 out_q", out_q_b, 64'h88);

    // degenerate single pair
    @(negedge clk);
    key_c = 1'b1;
    #1;
    check("deg k1 out", 64'(out_c), 64'h1);
    check("deg k1 hit", 64'(hit_c), 64'h1);
    check("deg k1 dup", 64'(dup_c), 64'h0);
    @(posedge clk); #1;
    check("deg k1 out_q", 64'(out_q_c), 64'h1);
    @(negedge clk);
    key_c = 1'b0;
    #1;
    check("deg k0 out", 64'(out_c), 64'h0);
    check("deg k0 hit", 64'(hit_c), 64'h0);
    @(posedge clk); #1;
    check("deg k0 hit_q", 64'(hit_q_c), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_key.md
# mux_key

Parameterized keyed multiplexer: selects one data word from a packed key/value lookup table by exact key match. It is the generic selection primitive used across the CPU datapath, including load/store width decode, byte-lane extraction, and write-mask generation in the RAM block. The combinational output serves same-cycle consumers. A registered copy, a match flag and a duplicate-key flag serve pipelined consumers and checkers.

## Interface
- NR_KEY, default 2: number of key/value pairs; must be ≥1.
- KEY_LEN, default 1: key width in bits; must be ≥1.
- DATA_LEN, default 1: data width in bits; must be ≥1.
- PAIR_LEN (derived, not overridable): KEY_LEN+DATA_LEN.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key  input  KEY_LEN  lookup key.
- lut  input  NR_KEY*PAIR_LEN  packed table.
- out  output  DATA_LEN  combinational selected data.
- hit  output  1  combinational: at least one pair key equals `key`.
- dup  output  1  combinational: two or more pair keys equal `key`.
- out_q  output  DATA_LEN  `out` registered.
- hit_q  output  1  `hit` registered.
- dup_q  output  1  `dup` registered.

## Operation
- Table packing matches concatenation order {key_0, data_0, key_1, data_1, …}.
  - Pair i occupies lut[NR_KEY*PAIR_LEN-1-i*PAIR_LEN -: PAIR_LEN].
  - Within a pair, the key is the upper KEY_LEN bits and the data is the lower DATA_LEN bits.
  - Pair 0 is the first pair listed and sits in the MSBs.
- Match i is asserted when key_i == key, compared bitwise over all KEY_LEN bits.
- Selection rules for `out`:
  - Exactly one match: `out` = that pair's data.
  - Multiple matches: lowest index (first listed) wins.
  - No match: `out` = all zeros.
- hit = OR of all matches.
- dup = 1 when the popcount of matches is ≥2.
- Outputs are purely combinational from key and lut. There are no latches; every output bit is driven for every input combination.
- X/Z on key or lut is not a supported operating condition.
- The pair count is unbounded in principle. The implementation must work for NR_KEY = 1 … 64 and any KEY_LEN, DATA_LEN ≤ 64.

## Timing
- out, hit and dup have zero-cycle latency: they settle within the same cycle that key or lut changes.
- Registered outputs:
  - On each rising clk, out_q ← out, hit_q ← hit, dup_q ← dup.
  - Latency is exactly 1 cycle.
  - There is no enable; the registers update every cycle.
- Reset:
  - While rst_n = 0, out_q = 0, hit_q = 0 and dup_q = 0, regardless of clk.
  - Reset assertion takes effect immediately (asynchronous).
  - After rst_n rises, the first rising clk captures current values.
  - Combinational outputs ignore rst_n.
- Simultaneous change of key and lut is handled as a single new lookup; there is no ordering dependency.

## Test plan
- Wmask table, NR_KEY=4, KEY_LEN=3, DATA_LEN=8, lut={3'd0,8'h01,3'd1,8'h03,3'd2,8'h0f,3'd3,8'hff}:
  - key=2 -> out=8'h0f, hit=1, dup=0.
  - Next rising clk -> out_q=8'h0f, hit_q=1.
- Same table, key=3'd5 -> out=8'h00, hit=0, dup=0.
- Duplicate keys, lut={3'd1,8'hAA,3'd1,8'h55,3'd0,8'h11,3'd2,8'h22}:
  - key=1 -> out=8'hAA, hit=1, dup=1.
  - key=0 -> out=8'h11, dup=0.
- Byte-lane mux, NR_KEY=8, KEY_LEN=3, DATA_LEN=64, data_i = ZEXT of byte i of 64'h8877665544332211:
  - Sweep key 0..7 -> out = 0x11,0x22,…,0x88, zero-extended to 64 bits.
- Reset mid-operation:
  - With out_q=8'hff, drive rst_n=0 between clock edges -> out_q, hit_q and dup_q go to 0 immediately.
  - While held in reset, those registered outputs stay 0 across edges.
  - On release, the next rising clk reloads out_q from the current out.
- Degenerate NR_KEY=1, KEY_LEN=1, DATA_LEN=1, lut={1'b1,1'b1}:
  - key=1 -> out=1, hit=1.
  - key=0 -> out=0, hit=0.
